conv_task_sequencer: RTL and testbench
======================================

// Module: conv_task_sequencer
// PURPOSE
//  Parametrised per-layer control sequencer for the conv/accumulate/maxpool datapath.
//  Replaces the fixed 128x128, 8-channel hard-coded schedule with these features:
//   - feature-map size and input-channel count, set at run time and latched at start;
//   - prime depth and flush length, set by parameters;
//   - a start/done handshake, back-pressure, a maxpool window and abort.
//  Sits between the input-stream controller and the conv, accumulator and maxpool units.
// PARAMETERS
//  DIM_W      8  width of cfg_col_num / cfg_row_num (max map 255x255)
//  CH_W       4  width of cfg_ch_num and ch_idx (max 15 channels)
//  PRIME_ROWS 2  rows streamed into the line buffers before conv output is valid
//  FLUSH_CYC  1  clk cycles that rst_n_conv is held low between channels (>=1)
//  CNT_W      2*DIM_W+2  beat counter width (localparam, derived; not overridable)
// PORTS
//  clk              in   1      clock
//  rst_n            in   1      reset, asynchronous, active-low
//  start            in   1      1-cycle pulse; latches cfg_* and begins a task
//  abort            in   1      synchronous abort; returns to IDLE
//  cfg_col_num      in   DIM_W  feature-map columns
//  cfg_row_num      in   DIM_W  feature-map rows
//  cfg_ch_num       in   CH_W   input channels to accumulate
//  valid_in         in   1      a pixel beat is presented this cycle
//  in_ready         out  1      sequencer accepts beats (state PRIME or RUN)
//  rst_n_conv       out  1      active-low conv line-buffer/window clear
//  valid_in_conv    out  1      conv unit enable
//  valid_in_accu    out  1      accumulator enable (conv output valid)
//  valid_in_maxpool out  1      maxpool enable (final-channel accumulation)
//  ch_idx           out  CH_W   channel currently being processed
//  busy             out  1      task in progress (state not IDLE)
//  task_over        out  1      1-cycle done pulse
// BEHAVIOUR
//  Reset values and outputs
//   - Reset and IDLE values: in_ready=0, rst_n_conv=1, all valid_*=0, ch_idx=0, busy=0, task_over=0.
//   - All outputs are registered.
//  Beat definition and latency
//   - A beat is a clk edge with valid_in=1 && in_ready=1.
//   - valid_in is ignored when in_ready=0; upstream must hold its data.
//   - A state change happens on the edge that accepts the terminal beat.
//   - Outputs reflect the new state from the following cycle (1-cycle latency).
//  IDLE
//   - start=1 latches C=cfg_col_num, R=cfg_row_num, N=cfg_ch_num and goes to PRIME.
//   - If C, R or N is zero, go instead to DONE; no valid_* is ever raised.
//  PRIME
//   - in_ready=1, valid_in_conv=1, valid_in_accu=0.
//   - Counts PRIME_ROWS*C beats, then goes to RUN.
//  RUN
//   - in_ready=1, valid_in_conv=1, valid_in_accu=1.
//   - valid_in_maxpool=1 only when ch_idx==N-1.
//   - Counts C*R beats.
//   - On the terminal beat: if ch_idx<N-1, go to FLUSH; otherwise go to DONE.
//  FLUSH
//   - in_ready=0, rst_n_conv=0, valid_in_conv=0, valid_in_accu=0.
//   - Lasts exactly FLUSH_CYC cycles, independent of valid_in.
//   - Exit: ch_idx increments, beat counter clears, go to PRIME.
//  DONE
//   - Held for one cycle: task_over=1, busy=1, other outputs at their IDLE values.
//   - Next state is IDLE.
//  Per-channel beat count
//   - Each channel consumes exactly (PRIME_ROWS+R)*C beats.
//   - Stalls (valid_in=0) freeze the counter and state; outputs hold their values.
//  Arithmetic
//   - Terminal counts are compared against CNT_W-bit products.
//   - Maximum case 255*255 + PRIME_ROWS*255 must not overflow.
//   - The counter never wraps within a task.
//  Boundary conditions
//   - start while busy: ignored; latched cfg_* does not change mid-task.
//   - abort in any state: next cycle IDLE, outputs at reset values, no task_over. abort has priority over start.
//   - start and abort in the same cycle from IDLE: stay in IDLE.
//   - N=1: no FLUSH; valid_in_maxpool covers the only RUN phase.
//   - rst_n asserted mid-task: immediate asynchronous return to IDLE values.
// TESTING
//  T1 (C=4, R=4, N=2, valid_in always 1, start at cycle 0):
//     - conv high cycles 1-24, accu high 9-24.
//     - rst_n_conv low cycle 25.
//     - conv 26-49, accu and maxpool 34-49.
//     - task_over pulse cycle 50; ch_idx=1 during 26-49.
//  T2 (T1 config, valid_in toggling 1/0):
//     - Same beat counts: 24 beats per channel, 16 beats with accu high per channel.
//     - State frozen on the zero cycles; task_over after 48 beats plus flush.
//  T3 (C=3, R=2, N=1):
//     - No FLUSH; maxpool high for exactly 6 beats after 6 prime beats.
//     - task_over at cycle 13.
//  T4 (cfg_ch_num=0 with start):
//     - task_over the next cycle; conv, accu and maxpool never high.
//  T5 (abort in RUN of ch 1 under T1, and a second start while busy):
//     - abort: IDLE next cycle, no task_over.
//     - second start while busy: ignored.
//  T6 (rst_n low mid-PRIME; C=255, R=255, N=15 overflow check):
//     - rst_n low mid-PRIME: outputs at reset values immediately.
//     - Overflow check: every channel accepts 65535 beats, no counter wrap.

Source files
------------

// File: rtl/conv_task_sequencer_if.sv
// Handshake and control bundle between the upstream stream controller and the
// conv/accumulate/maxpool task sequencer.
interface conv_task_sequencer_if #(
    parameter int DIM_W = 8,
    parameter int CH_W  = 4
);
    logic             start;
    logic             abort;
    logic [DIM_W-1:0] cfg_col_num;
    logic [DIM_W-1:0] cfg_row_num;
    logic [CH_W-1:0]  cfg_ch_num;
    logic             valid_in;
    logic             in_ready;
    logic             rst_n_conv;
    logic             valid_in_conv;
    logic             valid_in_accu;
    logic             valid_in_maxpool;
    logic [CH_W-1:0]  ch_idx;
    logic             busy;
    logic             task_over;

    modport master (
        output start, abort, cfg_col_num, cfg_row_num, cfg_ch_num, valid_in,
        input  in_ready, rst_n_conv, valid_in_conv, valid_in_accu,
               valid_in_maxpool, ch_idx, busy, task_over
    );

    modport slave (
        input  start, abort, cfg_col_num, cfg_row_num, cfg_ch_num, valid_in,
        output in_ready, rst_n_conv, valid_in_conv, valid_in_accu,
               valid_in_maxpool, ch_idx, busy, task_over
    );
endinterface

// File: rtl/conv_task_sequencer.sv
// Per-layer control sequencer: primes the conv line buffers, runs the accumulate
// phase per input channel, flushes between channels and signals task completion.
module conv_task_sequencer #(
    parameter int DIM_W      = 8,
    parameter int CH_W       = 4,
    parameter int PRIME_ROWS = 2,
    parameter int FLUSH_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_task_sequencer_if.slave  bus
);
    localparam int CNT_W = 2*DIM_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  n_q, n_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             rst_n_conv_q, rst_n_conv_d;
    logic             conv_q, conv_d;
    logic             accu_q, accu_d;
    logic             maxpool_q, maxpool_d;
    logic             busy_q, busy_d;
    logic             task_over_q, task_over_d;

    logic [CNT_W-1:0] prime_last_s;
    logic [CNT_W-1:0] chan_last_s;
    logic             beat_s;

    // One counter spans prime and run of a channel; it also times the flush gap.
    assign prime_last_s = CNT_W'(PRIME_ROWS) * CNT_W'(col_q) - CNT_W'(1);
    assign chan_last_s  = (CNT_W'(PRIME_ROWS) + CNT_W'(row_q)) * CNT_W'(col_q) - CNT_W'(1);
    assign beat_s       = bus.valid_in & in_ready_q;

    // Next-state, counters and registered-output decode of the next state.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        n_d     = n_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = S_IDLE;
            ch_d    = {CH_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        col_d = bus.cfg_col_num;
                        row_d = bus.cfg_row_num;
                        n_d   = bus.cfg_ch_num;
                        ch_d  = {CH_W{1'b0}};
                        cnt_d = {CNT_W{1'b0}};
                        if ((bus.cfg_col_num == {DIM_W{1'b0}}) || (bus.cfg_row_num == {DIM_W{1'b0}}) ||
                            (bus.cfg_ch_num == {CH_W{1'b0}})) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_PRIME;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRIME: begin
                    if (beat_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == prime_last_s) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_PRIME;
                        end
                    end else begin
                        state_d = S_PRIME;
                    end
                end
                S_RUN: begin
                    if (beat_s && (cnt_q == chan_last_s)) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (ch_q == n_q - CH_W'(1)) begin
                            state_d = S_DONE;
                            ch_d    = {CH_W{1'b0}};
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end else if (beat_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        ch_d    = ch_q + CH_W'(1);
                        state_d = S_PRIME;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    ch_d    = {CH_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end

        in_ready_d   = (state_d == S_PRIME) || (state_d == S_RUN);
        conv_d       = in_ready_d;
        rst_n_conv_d = (state_d != S_FLUSH);
        accu_d       = (state_d == S_RUN);
        maxpool_d    = (state_d == S_RUN) && (ch_d == n_d - CH_W'(1));
        busy_d       = (state_d != S_IDLE);
        task_over_d  = (state_d == S_DONE);
    end

    // State, latched configuration, counters and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= {DIM_W{1'b0}};
            row_q        <= {DIM_W{1'b0}};
            n_q          <= {CH_W{1'b0}};
            ch_q         <= {CH_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            in_ready_q   <= 1'b0;
            rst_n_conv_q <= 1'b1;
            conv_q       <= 1'b0;
            accu_q       <= 1'b0;
            maxpool_q    <= 1'b0;
            busy_q       <= 1'b0;
            task_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            n_q          <= n_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            rst_n_conv_q <= rst_n_conv_d;
            conv_q       <= conv_d;
            accu_q       <= accu_d;
            maxpool_q    <= maxpool_d;
            busy_q       <= busy_d;
            task_over_q  <= task_over_d;
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.rst_n_conv       = rst_n_conv_q;
    assign bus.valid_in_conv    = conv_q;
    assign bus.valid_in_accu    = accu_q;
    assign bus.valid_in_maxpool = maxpool_q;
    assign bus.ch_idx           = ch_q;
    assign bus.busy             = busy_q;
    assign bus.task_over        = task_over_q;
endmodule

// File: tb/tb_conv_task_sequencer.sv
// Directed bench for conv_task_sequencer: cycle-exact schedules, stalls, zero
// configuration, abort, asynchronous reset and the largest feature map.
module tb_conv_task_sequencer;
    localparam int DIM_W = 8;
    localparam int CH_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    conv_task_sequencer_if #(.DIM_W(DIM_W), .CH_W(CH_W)) bus ();

    conv_task_sequencer #(
        .DIM_W(DIM_W), .CH_W(CH_W), .PRIME_ROWS(2), .FLUSH_CYC(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {in_ready, rst_n_conv, conv, accu, maxpool, busy, task_over, ch_idx}
    function automatic logic [10:0] obs();
        return {bus.in_ready, bus.rst_n_conv, bus.valid_in_conv, bus.valid_in_accu,
                bus.valid_in_maxpool, bus.busy, bus.task_over, bus.ch_idx};
    endfunction

    function automatic logic [10:0] expv(bit ir, bit rc, bit cv, bit ac, bit mp,
                                         bit bz, bit to, logic [3:0] ch);
        return {ir, rc, cv, ac, mp, bz, to, ch};
    endfunction

    localparam logic [10:0] IDLE_V = 11'b01000000000;

    // Hand-derived schedule for C=4, R=4, N=2 with a beat every cycle.
    function automatic logic [10:0] t1_exp(int cyc);
        bit cv, ac, mp, bz;
        cv = (cyc >= 1 && cyc <= 24) || (cyc >= 26 && cyc <= 49);
        ac = (cyc >= 9 && cyc <= 24) || (cyc >= 34 && cyc <= 49);
        mp = (cyc >= 34 && cyc <= 49);
        bz = (cyc >= 1 && cyc <= 50);
        return expv(cv, cyc != 25, cv, ac, mp, bz, cyc == 50,
                    (cyc >= 26 && cyc <= 49) ? 4'd1 : 4'd0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(logic [7:0] c, logic [7:0] r, logic [3:0] n);
        bus.cfg_col_num = c;
        bus.cfg_row_num = r;
        bus.cfg_ch_num  = n;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.valid_in = 1'b0;
        set_cfg(8'd0, 8'd0, 4'd0);
        #12;
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset got=%b exp=%b", obs(), IDLE_V);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_release got=%b exp=%b", obs(), IDLE_V);
        end
    endtask

    task automatic test_two_channel();
        set_cfg(8'd4, 8'd4, 4'd2);
        bus.valid_in = 1'b1;
        bus.start    = 1'b1;
        for (int cyc = 1; cyc <= 52; cyc++) begin
            step();
            bus.start = 1'b0;
            vectors++;
            if (obs() !== t1_exp(cyc)) begin
                miscompares++;
                $display("FAIL two_channel cyc=%0d got=%b exp=%b", cyc, obs(), t1_exp(cyc));
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_stall();
        int beats_conv = 0, beats_accu = 0, beats_mp = 0, to_cyc = -1, to_cnt = 0;
        set_cfg(8'd4, 8'd4, 4'd2);
        bus.valid_in = 1'b0;
        bus.start    = 1'b1;
        for (int cyc = 1; cyc <= 110; cyc++) begin
            step();
            bus.start    = 1'b0;
            bus.valid_in = (cyc % 2 == 0);
            if (bus.valid_in && bus.in_ready) begin
                beats_conv += int'(bus.valid_in_conv);
                beats_accu += int'(bus.valid_in_accu);
                beats_mp   += int'(bus.valid_in_maxpool);
            end
            if (bus.task_over) begin
                to_cnt++;
                if (to_cyc < 0) to_cyc = cyc;
            end
            if (cyc == 17 || cyc == 49 || cyc == 60) begin
                logic [10:0] e;
                e = (cyc == 17) ? expv(1, 1, 1, 1, 0, 1, 0, 4'd0) :
                    (cyc == 49) ? expv(0, 0, 0, 0, 0, 1, 0, 4'd0) :
                                  expv(1, 1, 1, 0, 0, 1, 0, 4'd1);
                vectors++;
                if (obs() !== e) begin
                    miscompares++;
                    $display("FAIL stall_state cyc=%0d got=%b exp=%b", cyc, obs(), e);
                end
            end
        end
        bus.valid_in = 1'b0;
        vectors++;
        if (beats_conv != 48) begin
            miscompares++;
            $display("FAIL stall_conv_beats got=%0d exp=48", beats_conv);
        end
        vectors++;
        if (beats_accu != 32) begin
            miscompares++;
            $display("FAIL stall_accu_beats got=%0d exp=32", beats_accu);
        end
        vectors++;
        if (beats_mp != 16) begin
            miscompares++;
            $display("FAIL stall_maxpool_beats got=%0d exp=16", beats_mp);
        end
        vectors++;
        if (to_cyc != 97 || to_cnt != 1) begin
            miscompares++;
            $display("FAIL stall_task_over got_cyc=%0d got_cnt=%0d exp_cyc=97 exp_cnt=1", to_cyc, to_cnt);
        end
    endtask

    task automatic test_single_channel();
        set_cfg(8'd3, 8'd2, 4'd1);
        bus.valid_in = 1'b1;
        bus.start    = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            logic [10:0] e;
            bit cv, ac;
            step();
            bus.start = 1'b0;
            cv = (cyc >= 1 && cyc <= 12);
            ac = (cyc >= 7 && cyc <= 12);
            e  = expv(cv, 1, cv, ac, ac, cyc <= 13, cyc == 13, 4'd0);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL single_channel cyc=%0d got=%b exp=%b", cyc, obs(), e);
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_zero_cfg();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_cfg(8'd4, 8'd4, 4'd0);
            else        set_cfg(8'd0, 8'd4, 4'd2);
            bus.valid_in = 1'b1;
            bus.start    = 1'b1;
            for (int cyc = 1; cyc <= 3; cyc++) begin
                logic [10:0] e;
                step();
                bus.start = 1'b0;
                e = (cyc == 1) ? expv(0, 1, 0, 0, 0, 1, 1, 4'd0) : IDLE_V;
                vectors++;
                if (obs() !== e) begin
                    miscompares++;
                    $display("FAIL zero_cfg k=%0d cyc=%0d got=%b exp=%b", k, cyc, obs(), e);
                end
            end
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic test_abort_busy_start();
        set_cfg(8'd4, 8'd4, 4'd2);
        bus.valid_in = 1'b1;
        bus.start    = 1'b1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            logic [10:0] e;
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (cyc == 10) begin
                set_cfg(8'd2, 8'd2, 4'd1);
                bus.start = 1'b1;
            end
            if (cyc == 40) bus.abort = 1'b1;
            if (cyc == 47) begin
                set_cfg(8'd4, 8'd4, 4'd2);
                bus.start = 1'b1;
                bus.abort = 1'b1;
            end
            e = (cyc <= 40) ? t1_exp(cyc) : IDLE_V;
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL abort_busy_start cyc=%0d got=%b exp=%b", cyc, obs(), e);
            end
        end
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [10:0] e;
        set_cfg(8'd255, 8'd255, 4'd15);
        bus.valid_in = 1'b1;
        bus.start    = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            step();
            bus.start = 1'b0;
        end
        e = expv(1, 1, 1, 0, 0, 1, 0, 4'd0);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL async_reset_prime got=%b exp=%b", obs(), e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL async_reset_immediate got=%b exp=%b", obs(), IDLE_V);
        end
        #2;
        rst_n = 1'b1;
        bus.valid_in = 1'b0;
        step();
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL async_reset_after got=%b exp=%b", obs(), IDLE_V);
        end
    endtask

    task automatic test_max_map();
        int prime_beats = 0, accu_beats = 0, mp_beats = 0;
        set_cfg(8'd255, 8'd255, 4'd15);
        bus.valid_in = 1'b1;
        bus.start    = 1'b1;
        for (int cyc = 1; cyc <= 65537; cyc++) begin
            step();
            bus.start = 1'b0;
            if (bus.in_ready) begin
                prime_beats += int'(bus.valid_in_conv && !bus.valid_in_accu);
                accu_beats  += int'(bus.valid_in_accu);
                mp_beats    += int'(bus.valid_in_maxpool);
            end
            if (cyc == 65536 || cyc == 65537) begin
                logic [10:0] e;
                e = (cyc == 65536) ? expv(0, 0, 0, 0, 0, 1, 0, 4'd0) :
                                     expv(1, 1, 1, 0, 0, 1, 0, 4'd1);
                vectors++;
                if (obs() !== e) begin
                    miscompares++;
                    $display("FAIL max_map_edge cyc=%0d got=%b exp=%b", cyc, obs(), e);
                end
            end
        end
        vectors++;
        if (prime_beats != 510 + 1 || accu_beats != 65025 || mp_beats != 0) begin
            miscompares++;
            $display("FAIL max_map_beats prime=%0d accu=%0d mp=%0d exp=511/65025/0",
                     prime_beats, accu_beats, mp_beats);
        end
        bus.abort = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.valid_in = 1'b0;
        vectors++;
        if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL max_map_abort got=%b exp=%b", obs(), IDLE_V);
        end
    endtask

    initial begin
        test_reset();
        test_two_channel();
        test_stall();
        test_single_channel();
        test_zero_cfg();
        test_abort_busy_start();
        test_async_reset();
        test_max_map();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
